// File: rtl/lcd_sequencer_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style LCD bus sequencer.
//   lcd_state_e   - sequencer FSM states. The POLL_* states are only reachable when
//                   LCD_BUSY_POLL_EN is defined.
//   LCD_CMD_*     - instruction codes that need the long post-write wait.
//   DEF_*         - default timing constants, in clock cycles.
//   lcd_max       - helper that sizes the shared delay counter.
//   is_long_cmd   - selects the clear/home wait time.
package lcd_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        POLL_SETUP,
        POLL_PULSE,
        POLL_HOLD
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    // 8'h03 is also a "return home" encoding (bit 0 is don't-care), so the
    // long-wait range ends here.
    localparam logic [7:0] LCD_CMD_LONG_MAX = 8'h03;

    localparam int DEF_SETUP_CYCLES   = 2;
    localparam int DEF_PULSE_CYCLES   = 12;
    localparam int DEF_HOLD_CYCLES    = 2;
    localparam int DEF_EXEC_CYCLES    = 2000;
    localparam int DEF_CLEAR_CYCLES   = 82000;
    localparam int DEF_POWERON_CYCLES = 750000;

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home are slow on the controller. They are instructions (RS=0)
    // with a byte value of 8'h01..8'h03.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data >= LCD_CMD_CLEAR) && (data <= LCD_CMD_LONG_MAX);
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// lcd_cmd_if: byte command channel into the LCD sequencer, using valid/ready.
//   cmdValid - producer has a byte (master -> slave)
//   cmdReady - sequencer can accept a byte (slave -> master)
//   cmdRS    - 0 = instruction register, 1 = data register (master -> slave)
//   cmdData  - byte to write (master -> slave)
// A byte transfers on a posedge where cmdValid && cmdReady.
interface lcd_cmd_if;
    logic       cmdValid;
    logic       cmdReady;
    logic       cmdRS;
    logic [7:0] cmdData;

    modport master (output cmdValid, output cmdRS, output cmdData, input cmdReady);
    modport slave  (input cmdValid, input cmdRS, input cmdData, output cmdReady);
endinterface

// File: rtl/lcd_sequencer_delay_counter.sv
// lcd_delay_counter: loadable down-counter that times every phase of the LCD sequencer.
//   clk, rst  - clock and synchronous active-high reset (reset loads RST_VALUE)
//   i_load    - load i_value on this edge
//   i_value   - value to load (phase length minus one)
//   o_done    - count is zero, so the current phase ends at the next edge
// When the count reaches zero it stays there; it does not wrap.
module lcd_delay_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_VALUE;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780-style 8-bit LCD bus sequencer.
// It accepts one command or data byte per valid/ready handshake. For each byte it
// drives setup, the E pulse and hold, then waits for the LCD to finish before it
// sets cmdReady again.
//   clk, rst      - clock and synchronous active-high reset (reset also reruns the
//                   power-on wait)
//   cmd           - lcd_cmd_if.slave command channel (cmdValid/cmdReady/cmdRS/cmdData)
//   lcdRS, lcdRW, lcdE            - LCD control lines
//   lcdDataOut, lcdDataOutEn      - bus drive value and tristate enable
//   lcdDataIn                     - sampled bus value (used by busy polling)
//   statusByte                    - last byte read by a busy poll
// Build option LCD_BUSY_POLL_EN: the fixed post-write wait is replaced by a loop that
// reads the busy flag. Without it, lcdRW stays 0 and statusByte stays 8'h00.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int EXEC_CYCLES    = DEF_EXEC_CYCLES,
    parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
    parameter int POWERON_CYCLES = DEF_POWERON_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    lcd_cmd_if.slave   cmd,
    output logic       lcdRS,
    output logic       lcdRW,
    output logic       lcdE,
    output logic [7:0] lcdDataOut,
    output logic       lcdDataOutEn,
    input  logic [7:0] lcdDataIn,
    output logic [7:0] statusByte
);
    localparam int MAX_CYCLES = lcd_max(lcd_max(lcd_max(SETUP_CYCLES, PULSE_CYCLES),
                                                lcd_max(HOLD_CYCLES, EXEC_CYCLES)),
                                        lcd_max(CLEAR_CYCLES, POWERON_CYCLES));
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    // The counter holds "cycles left minus one", so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_POWERON = CNT_W'(POWERON_CYCLES - 1);
`ifndef LCD_BUSY_POLL_EN
    localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(CLEAR_CYCLES - 1);
`endif

    lcd_state_e       r_state, w_state_next;
    logic             r_lcd_rs, w_rs_next;
    logic             r_lcd_rw, w_rw_next;
    logic             r_lcd_e, w_e_next;
    logic [7:0]       r_data_out, w_data_next;
    logic             r_data_en, w_en_next;
    logic             r_cmd_ready, w_ready_next;
    logic [7:0]       r_status, w_status_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic             w_done;

    lcd_delay_counter #(
        .WIDTH     (CNT_W),
        .RST_VALUE (LD_POWERON)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_value),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_lcd_rs    <= 1'b0;
            r_lcd_rw    <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_data_out  <= 8'h00;
            r_data_en   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_status    <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_lcd_rs    <= w_rs_next;
            r_lcd_rw    <= w_rw_next;
            r_lcd_e     <= w_e_next;
            r_data_out  <= w_data_next;
            r_data_en   <= w_en_next;
            r_cmd_ready <= w_ready_next;
            r_status    <= w_status_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rs_next     = r_lcd_rs;
        w_rw_next     = r_lcd_rw;
        w_e_next      = r_lcd_e;
        w_data_next   = r_data_out;
        w_en_next     = r_data_en;
        w_ready_next  = r_cmd_ready;
        w_status_next = r_status;
        w_load        = 1'b0;
        w_load_value  = '0;

        case (r_state)
            INIT: begin
                if (w_done) begin
                    w_state_next = IDLE;
                    w_ready_next = 1'b1;
                end
            end
            IDLE: begin
                if (cmd.cmdValid && r_cmd_ready) begin
                    w_state_next = SETUP;
                    w_rs_next    = cmd.cmdRS;
                    w_rw_next    = 1'b0;
                    w_data_next  = cmd.cmdData;
                    w_en_next    = 1'b1;
                    w_ready_next = 1'b0;
                    w_load       = 1'b1;
                    w_load_value = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_done) begin
                    w_state_next = PULSE;
                    w_e_next     = 1'b1;
                    w_load       = 1'b1;
                    w_load_value = LD_PULSE;
                end
            end
            PULSE: begin
                if (w_done) begin
                    w_state_next = HOLD;
                    w_e_next     = 1'b0;
                    w_load       = 1'b1;
                    w_load_value = LD_HOLD;
                end
            end
            HOLD: begin
                if (w_done) begin
                    w_en_next    = 1'b0;
                    w_load       = 1'b1;
`ifdef LCD_BUSY_POLL_EN
                    w_state_next = POLL_SETUP;
                    w_rs_next    = 1'b0;
                    w_rw_next    = 1'b1;
                    w_load_value = LD_SETUP;
`else
                    w_state_next = WAIT;
                    w_load_value = is_long_cmd(r_lcd_rs, r_data_out) ? LD_CLEAR : LD_EXEC;
`endif
                end
            end
`ifdef LCD_BUSY_POLL_EN
            POLL_SETUP: begin
                if (w_done) begin
                    w_state_next = POLL_PULSE;
                    w_e_next     = 1'b1;
                    w_load       = 1'b1;
                    w_load_value = LD_PULSE;
                end
            end
            POLL_PULSE: begin
                // Capture the status on the last cycle before E falls.
                if (w_done) begin
                    w_state_next  = POLL_HOLD;
                    w_e_next      = 1'b0;
                    w_status_next = lcdDataIn;
                    w_load        = 1'b1;
                    w_load_value  = LD_HOLD;
                end
            end
            POLL_HOLD: begin
                if (w_done) begin
                    if (r_status[7]) begin
                        w_state_next = POLL_SETUP;
                        w_load       = 1'b1;
                        w_load_value = LD_SETUP;
                    end else begin
                        w_state_next = IDLE;
                        w_rw_next    = 1'b0;
                        w_ready_next = 1'b1;
                    end
                end
            end
`else
            WAIT: begin
                if (w_done) begin
                    w_state_next = IDLE;
                    w_ready_next = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

`ifndef LCD_BUSY_POLL_EN
    // The bus is never read in this build.
    logic w_unused_lcd_data_in;
    assign w_unused_lcd_data_in = ^lcdDataIn;
`endif

    assign cmd.cmdReady = r_cmd_ready;
    assign lcdRS        = r_lcd_rs;
    assign lcdRW        = r_lcd_rw;
    assign lcdE         = r_lcd_e;
    assign lcdDataOut   = r_data_out;
    assign lcdDataOutEn = r_data_en;
    assign statusByte   = r_status;
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: directed self-checking bench for lcd_sequencer, using short timing
// parameters (SETUP=2 PULSE=3 HOLD=2 EXEC=10 CLEAR=40 POWERON=20).
// Outputs are sampled 1 time unit after each rising edge. k counts edges after the
// accept edge N.
module tb_lcd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcdRS, lcdRW, lcdE, lcdDataOutEn;
    logic [7:0] lcdDataOut, lcdDataIn, statusByte;
    int         n_checks = 0;
    int         n_errors = 0;
    int         poll_cnt = 0;
    int         poll_base = 0;
    logic       e_prev = 1'b0;

    always #5 clk = ~clk;

    lcd_cmd_if cmd();

    lcd_sequencer #(
        .SETUP_CYCLES   (2),
        .PULSE_CYCLES   (3),
        .HOLD_CYCLES    (2),
        .EXEC_CYCLES    (10),
        .CLEAR_CYCLES   (40),
        .POWERON_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .lcdRS        (lcdRS),
        .lcdRW        (lcdRW),
        .lcdE         (lcdE),
        .lcdDataOut   (lcdDataOut),
        .lcdDataOutEn (lcdDataOutEn),
        .lcdDataIn    (lcdDataIn),
        .statusByte   (statusByte)
    );

    // LCD model: it reports busy for the first two reads of a transaction, then ready.
    always @(negedge clk) begin
        if (e_prev && !lcdE && lcdRW) poll_cnt <= poll_cnt + 1;
        e_prev <= lcdE;
    end
    assign lcdDataIn = ((poll_cnt - poll_base) < 2) ? 8'h80 : 8'h05;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one byte transfer. wait_cyc is the fixed post-HOLD wait. In the polling
    // build, three 7-cycle polls take 21 cycles.
    task automatic run_write(input logic rs, input logic [7:0] d, input int wait_cyc);
        int   guard;
        int   last;
        int   m;
        logic exp_e, exp_en, exp_rw, exp_rs;
        cmd.cmdRS    = rs;
        cmd.cmdData  = d;
        cmd.cmdValid = 1'b1;
        poll_base    = poll_cnt;
        guard = 0;
        while (!cmd.cmdReady && guard < 200) begin
            step();
            guard++;
        end
        check_val($sformatf("ready_before_%h", d), cmd.cmdReady, 1);
        step();                       // accept edge N
        cmd.cmdValid = 1'b0;          // change inputs while busy: bus must not follow
        cmd.cmdRS    = ~rs;
        cmd.cmdData  = ~d;
`ifdef LCD_BUSY_POLL_EN
        last = 7 + 21;
`else
        last = 7 + wait_cyc;
`endif
        for (int k = 0; k <= last; k++) begin
            exp_e  = (k >= 2 && k < 5);
            exp_en = (k < 7);
            exp_rw = 1'b0;
            exp_rs = rs;
`ifdef LCD_BUSY_POLL_EN
            if (k >= 7 && k < last) begin
                m      = (k - 7) % 7;
                exp_e  = (m >= 2 && m < 5);
                exp_rw = 1'b1;
            end
            if (k >= 7) exp_rs = 1'b0;
`else
            m = 0;
`endif
            check_val($sformatf("E_%h_k%0d", d, k), lcdE, exp_e);
            check_val($sformatf("EN_%h_k%0d", d, k), lcdDataOutEn, exp_en);
            check_val($sformatf("RDY_%h_k%0d", d, k), cmd.cmdReady, (k == last));
            check_val($sformatf("RW_%h_k%0d", d, k), lcdRW, exp_rw);
            check_val($sformatf("RS_%h_k%0d", d, k), lcdRS, exp_rs);
            check_val($sformatf("DOUT_%h_k%0d", d, k), lcdDataOut, d);
            if (k < last) step();
        end
`ifdef LCD_BUSY_POLL_EN
        check_val($sformatf("status_%h", d), statusByte, 8'h05);
        check_val($sformatf("polls_%h", d), poll_cnt - poll_base, 3);
`else
        check_val($sformatf("status_%h", d), statusByte, 8'h00);
`endif
        $display("txn rs=%0d data=%h wait=%0d ready_at=N+%0d", rs, d, wait_cyc, last);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         wait_cyc;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h41, 10};   // data write
        vecs[1] = '{1'b0, 8'h01, 40};   // clear
        vecs[2] = '{1'b1, 8'h01, 10};   // same byte to data register: short wait
        vecs[3] = '{1'b0, 8'h03, 40};   // top of long range
        vecs[4] = '{1'b0, 8'h04, 10};   // just above long range
        vecs[5] = '{1'b0, 8'h00, 10};   // just below long range

        // Hold cmdValid through reset and power-on; it must be ignored until ready.
        cmd.cmdValid = 1'b1;
        cmd.cmdRS    = 1'b1;
        cmd.cmdData  = 8'h41;
        rst = 1'b1;
        repeat (3) step();
        check_val("rst_ready", cmd.cmdReady, 0);
        check_val("rst_E", lcdE, 0);
        check_val("rst_EN", lcdDataOutEn, 0);
        check_val("rst_RS", lcdRS, 0);
        check_val("rst_RW", lcdRW, 0);
        check_val("rst_DOUT", lcdDataOut, 0);
        check_val("rst_status", statusByte, 0);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check_val($sformatf("poweron_ready_c%0d", i), cmd.cmdReady, (i == 20));
            check_val($sformatf("poweron_E_c%0d", i), lcdE, 0);
        end
        $display("txn power-on wait done");

        foreach (vecs[i]) run_write(vecs[i].rs, vecs[i].d, vecs[i].wait_cyc);

        // No extra transaction while cmdValid is low.
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("idle_E_c%0d", i), lcdE, 0);
            check_val($sformatf("idle_ready_c%0d", i), cmd.cmdReady, 1);
            check_val($sformatf("idle_EN_c%0d", i), lcdDataOutEn, 0);
        end

        // Reset in the middle of the E pulse.
        cmd.cmdRS    = 1'b1;
        cmd.cmdData  = 8'h55;
        cmd.cmdValid = 1'b1;
        step();                       // accept edge N
        cmd.cmdValid = 1'b0;
        repeat (3) step();            // k=3: inside PULSE
        check_val("midrst_E_before", lcdE, 1);
        rst = 1'b1;
        step();
        check_val("midrst_E", lcdE, 0);
        check_val("midrst_EN", lcdDataOutEn, 0);
        check_val("midrst_ready", cmd.cmdReady, 0);
        check_val("midrst_DOUT", lcdDataOut, 0);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check_val($sformatf("midrst_init_ready_c%0d", i), cmd.cmdReady, (i == 20));
        end
        $display("txn reset during pulse, re-init done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
